// File: rtl/shift_tx_if.sv
// Word-in / serial-out handshake bundle for shift_tx.
// The master supplies words; the slave (the transmitter) reports line and frame status.
interface shift_tx_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] din;
    logic              din_vld;
    logic              din_rdy;
    logic              y;
    logic              busy;
    logic              done;

    modport master (
        output din,
        output din_vld,
        input  din_rdy,
        input  y,
        input  busy,
        input  done
    );

    modport slave (
        input  din,
        input  din_vld,
        output din_rdy,
        output y,
        output busy,
        output done
    );
endinterface

// File: rtl/shift_tx.sv
// Framed parallel-in / serial-out transmitter: start(0), data LSB first,
// optional even parity, stop(1); each bit held CLK_PER_BIT clocks, line idles high.
module shift_tx #(
    parameter int DATA_W      = 8,
    parameter int CLK_PER_BIT = 4,
    parameter int PARITY_EN   = 0
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    shift_tx_if.slave  bus
);
    localparam int MAX_CNT = (CLK_PER_BIT > DATA_W) ? CLK_PER_BIT : DATA_W;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);
    localparam logic [CNT_W-1:0] LAST_CLK = CNT_W'(CLK_PER_BIT - 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PAR,
        S_STOP
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  clk_cnt_q, clk_cnt_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] sreg_q, sreg_d;
    logic              par_q, par_d;
    logic              y_q, y_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              last_clk;

    assign last_clk    = (clk_cnt_q == LAST_CLK);
    assign bus.din_rdy = (state_q == S_IDLE) && !sys_rst;
    assign bus.y       = y_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;

    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q;
        bit_cnt_d = bit_cnt_q;
        sreg_d    = sreg_q;
        par_d     = par_q;

        case (state_q)
            S_IDLE: begin
                if (bus.din_vld && bus.din_rdy) begin
                    state_d   = S_START;
                    sreg_d    = bus.din;
                    par_d     = ^bus.din;
                    clk_cnt_d = '0;
                    bit_cnt_d = '0;
                end
            end
            S_START: begin
                if (last_clk) begin
                    clk_cnt_d = '0;
                    state_d   = S_DATA;
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (last_clk) begin
                    clk_cnt_d = '0;
                    sreg_d    = sreg_q >> 1;
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = (PARITY_EN != 0) ? S_PAR : S_STOP;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end
            S_PAR: begin
                if (last_clk) begin
                    clk_cnt_d = '0;
                    state_d   = S_STOP;
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end
            S_STOP: begin
                if (last_clk) begin
                    clk_cnt_d = '0;
                    state_d   = S_IDLE;
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d   = S_IDLE;
                clk_cnt_d = '0;
                bit_cnt_d = '0;
            end
        endcase

        // Outputs are decoded from the upcoming state so they appear registered
        // in the same cycle the state takes effect.
        case (state_d)
            S_START: y_d = 1'b0;
            S_DATA:  y_d = sreg_d[0];
            S_PAR:   y_d = par_d;
            default: y_d = 1'b1;
        endcase
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_STOP) && (clk_cnt_d == LAST_CLK);
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q   <= S_IDLE;
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            sreg_q    <= '0;
            par_q     <= 1'b0;
            y_q       <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            sreg_q    <= sreg_d;
            par_q     <= par_d;
            y_q       <= y_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end
endmodule
